// File: rtl/alu_pkg.sv
// Shared widths, port count and flag bit positions for the shared-ALU arbiter.
package alu_pkg;
    localparam int NPORTS   = 2;
    localparam int DATA_W   = 32;
    localparam int SHAMT_W  = 5;
    localparam int FN_W     = 4;
    localparam int FLAGS_W  = 4;

    localparam int FLAG_CF  = 3;
    localparam int FLAG_ZF  = 2;
    localparam int FLAG_VF  = 1;
    localparam int FLAG_SF  = 0;

    typedef struct packed {
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [SHAMT_W-1:0] shamt;
        logic [FN_W-1:0]    alufn;
    } op_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way grant: a lone eligible port wins; a tie goes to ptr, or to port 0 when fixed.
module rr_arb2 (
    input  logic [1:0] eligible,
    input  logic       ptr,
    input  logic       fixed,
    output logic [1:0] grant
);
    always_comb begin
        grant = eligible;
        if (eligible == 2'b11) begin
            grant = (fixed || !ptr) ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/alu_share_arb.sv
// Two ports share one external ALU: grant, register operands, capture the result
// into the winner's response slot two cycles after acceptance.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [DATA_W-1:0]  req_a0,
    input  logic [DATA_W-1:0]  req_b0,
    input  logic [DATA_W-1:0]  req_a1,
    input  logic [DATA_W-1:0]  req_b1,
    input  logic [SHAMT_W-1:0] req_shamt0,
    input  logic [SHAMT_W-1:0] req_shamt1,
    input  logic [FN_W-1:0]    req_alufn0,
    input  logic [FN_W-1:0]    req_alufn1,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [SHAMT_W-1:0] alu_shamt,
    output logic [FN_W-1:0]    alu_alufn,
    input  logic [DATA_W-1:0]  alu_r,
    input  logic [FLAGS_W-1:0] alu_flags,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [DATA_W-1:0]  rsp_r0,
    output logic [DATA_W-1:0]  rsp_r1,
    output logic [FLAGS_W-1:0] rsp_flags0,
    output logic [FLAGS_W-1:0] rsp_flags1
);
    op_t                 req_op [NPORTS];
    op_t                 op_reg;
    logic                op_valid_reg;
    logic                op_id_reg;
    logic                ptr_reg;
    logic [NPORTS-1:0]   busy;
    logic [NPORTS-1:0]   eligible;
    logic [NPORTS-1:0]   grant;
    logic [NPORTS-1:0]   handshake;
    logic [NPORTS-1:0]   capture;
    logic [DATA_W-1:0]   rsp_r_all [NPORTS];
    logic [FLAGS_W-1:0]  rsp_flags_all [NPORTS];

    assign req_op[0] = {req_a0, req_b0, req_shamt0, req_alufn0};
    assign req_op[1] = {req_a1, req_b1, req_shamt1, req_alufn1};

    // Reset and flush both block acceptance in the cycle they are asserted.
    assign eligible  = req_valid & ~busy & {NPORTS{~rst & ~flush}};
    assign req_ready = grant;

    rr_arb2 u_arb (
        .eligible (eligible),
        .ptr      (ptr_reg),
        .fixed    (FIXED_PRIO != 0),
        .grant    (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg       <= '0;
            op_valid_reg <= 1'b0;
            op_id_reg    <= 1'b0;
            ptr_reg      <= 1'b0;
        end else begin
            op_valid_reg <= |grant;
            if (|grant) begin
                op_reg    <= grant[1] ? req_op[1] : req_op[0];
                op_id_reg <= grant[1];
                ptr_reg   <= grant[0];
            end
        end
    end

    assign alu_a     = op_reg.a;
    assign alu_b     = op_reg.b;
    assign alu_shamt = op_reg.shamt;
    assign alu_alufn = op_reg.alufn;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_port
        logic                busy_reg;
        logic                rsp_valid_reg;
        logic [DATA_W-1:0]   rsp_r_reg;
        logic [FLAGS_W-1:0]  rsp_flags_reg;

        assign handshake[gi] = rsp_valid_reg & rsp_ready[gi];
        assign capture[gi]   = op_valid_reg & (int'(op_id_reg) == gi) & ~flush;

        // busy spans grant through the response handshake, so one request in flight per port.
        always_ff @(posedge clk) begin
            if (rst) begin
                busy_reg      <= 1'b0;
                rsp_valid_reg <= 1'b0;
                rsp_r_reg     <= '0;
                rsp_flags_reg <= '0;
            end else begin
                if (flush) begin
                    busy_reg      <= 1'b0;
                    rsp_valid_reg <= 1'b0;
                end else begin
                    if (grant[gi]) begin
                        busy_reg <= 1'b1;
                    end else if (handshake[gi]) begin
                        busy_reg <= 1'b0;
                    end
                    if (capture[gi]) begin
                        rsp_valid_reg <= 1'b1;
                    end else if (handshake[gi]) begin
                        rsp_valid_reg <= 1'b0;
                    end
                end
                if (capture[gi]) begin
                    rsp_r_reg     <= alu_r;
                    rsp_flags_reg <= alu_flags;
                end
            end
        end

        assign busy[gi]          = busy_reg;
        assign rsp_valid[gi]     = rsp_valid_reg;
        assign rsp_r_all[gi]     = rsp_r_reg;
        assign rsp_flags_all[gi] = rsp_flags_reg;
    end

    assign rsp_r0     = rsp_r_all[0];
    assign rsp_r1     = rsp_r_all[1];
    assign rsp_flags0 = rsp_flags_all[0];
    assign rsp_flags1 = rsp_flags_all[1];
endmodule

// File: tb/tb_alu_share_arb.sv
// Drives a round-robin and a fixed-priority instance with identical stimulus,
// each paired with a behavioural ALU, and checks grants and responses per cycle.
module tb_alu_share_arb;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [1:0]  req_valid, rsp_ready;
    logic [31:0] a0, b0, a1, b1;
    logic [4:0]  sh0, sh1;
    logic [3:0]  fn0, fn1;

    logic [1:0]  rr_req_ready, rr_rsp_valid, fx_req_ready, fx_rsp_valid;
    logic [31:0] rr_alu_a, rr_alu_b, rr_alu_r, rr_rsp_r0, rr_rsp_r1;
    logic [31:0] fx_alu_a, fx_alu_b, fx_alu_r, fx_rsp_r0, fx_rsp_r1;
    logic [4:0]  rr_alu_shamt, fx_alu_shamt;
    logic [3:0]  rr_alu_alufn, fx_alu_alufn, rr_alu_flags, fx_alu_flags;
    logic [3:0]  rr_rsp_flags0, rr_rsp_flags1, fx_rsp_flags0, fx_rsp_flags1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // 0 add, 1 sub, anything else xor; returns {flags, result}.
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] fn);
        logic [32:0] s;
        logic [31:0] r;
        logic [3:0]  f;
        f = 4'b0000;
        case (fn)
            4'h0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                f[FLAG_CF] = s[32];
                f[FLAG_VF] = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'h1: begin
                r = a - b;
                f[FLAG_CF] = (a < b);
                f[FLAG_VF] = (a[31] != b[31]) && (r[31] != a[31]);
            end
            default: r = a ^ b;
        endcase
        f[FLAG_ZF] = (r == 32'd0);
        f[FLAG_SF] = r[31];
        return {f, r};
    endfunction

    assign {rr_alu_flags, rr_alu_r} = alu_model(rr_alu_a, rr_alu_b, rr_alu_alufn);
    assign {fx_alu_flags, fx_alu_r} = alu_model(fx_alu_a, fx_alu_b, fx_alu_alufn);

    alu_share_arb #(.FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(rr_req_ready),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
        .req_shamt0(sh0), .req_shamt1(sh1), .req_alufn0(fn0), .req_alufn1(fn1),
        .alu_a(rr_alu_a), .alu_b(rr_alu_b), .alu_shamt(rr_alu_shamt), .alu_alufn(rr_alu_alufn),
        .alu_r(rr_alu_r), .alu_flags(rr_alu_flags),
        .rsp_valid(rr_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r0(rr_rsp_r0), .rsp_r1(rr_rsp_r1), .rsp_flags0(rr_rsp_flags0), .rsp_flags1(rr_rsp_flags1)
    );

    alu_share_arb #(.FIXED_PRIO(1)) dut_fx (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(fx_req_ready),
        .req_a0(a0), .req_b0(b0), .req_a1(a1), .req_b1(b1),
        .req_shamt0(sh0), .req_shamt1(sh1), .req_alufn0(fn0), .req_alufn1(fn1),
        .alu_a(fx_alu_a), .alu_b(fx_alu_b), .alu_shamt(fx_alu_shamt), .alu_alufn(fx_alu_alufn),
        .alu_r(fx_alu_r), .alu_flags(fx_alu_flags),
        .rsp_valid(fx_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_r0(fx_rsp_r0), .rsp_r1(fx_rsp_r1), .rsp_flags0(fx_rsp_flags0), .rsp_flags1(fx_rsp_flags1)
    );

    typedef struct packed {
        logic       rst;
        logic       flush;
        logic [1:0] rv;
        logic [1:0] rr;
        logic [1:0] ready_rr;
        logic [1:0] rspv_rr;
        logic [1:0] ready_fx;
        logic [1:0] rspv_fx;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic f, input logic [1:0] rv, input logic [1:0] rr,
                       input logic [1:0] qr, input logic [1:0] vr,
                       input logic [1:0] qf, input logic [1:0] vf);
        tbl.push_back('{r, f, rv, rr, qr, vr, qf, vf});
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Port 0 always carries 5+3 and port 1 carries 7-7 inside the table.
    task automatic chk_data(input string tag, input logic [1:0] v,
                            input logic [31:0] r0, input logic [3:0] f0,
                            input logic [31:0] r1, input logic [3:0] f1);
        if (v[0]) begin
            chk({tag, " rsp_r0"}, r0, 32'd8);
            chk({tag, " rsp_flags0"}, 32'(f0), 32'h0);
        end
        if (v[1]) begin
            chk({tag, " rsp_r1"}, r1, 32'd0);
            chk({tag, " rsp_flags1"}, 32'(f1), 32'b0100);
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
        a0 = 32'd5; b0 = 32'd3; sh0 = 5'd1; fn0 = 4'h0;
        a1 = 32'd7; b1 = 32'd7; sh1 = 5'd2; fn1 = 4'h1;

        add(1,0,2'b11,2'b11, 2'b00,2'b00, 2'b00,2'b00);
        add(0,0,2'b01,2'b11, 2'b01,2'b00, 2'b01,2'b00);
        add(0,0,2'b00,2'b11, 2'b00,2'b00, 2'b00,2'b00);
        add(0,0,2'b00,2'b11, 2'b00,2'b01, 2'b00,2'b01);
        add(0,0,2'b11,2'b01, 2'b10,2'b00, 2'b01,2'b00);
        add(0,0,2'b11,2'b01, 2'b01,2'b00, 2'b10,2'b00);
        add(0,0,2'b11,2'b01, 2'b00,2'b10, 2'b00,2'b01);
        add(0,0,2'b11,2'b01, 2'b00,2'b11, 2'b01,2'b10);
        add(0,0,2'b11,2'b01, 2'b01,2'b10, 2'b00,2'b10);
        add(0,0,2'b11,2'b01, 2'b00,2'b10, 2'b00,2'b11);
        add(0,0,2'b11,2'b11, 2'b00,2'b11, 2'b01,2'b10);
        add(0,0,2'b00,2'b11, 2'b00,2'b00, 2'b00,2'b00);
        add(0,0,2'b00,2'b11, 2'b00,2'b00, 2'b00,2'b01);
        add(0,0,2'b01,2'b11, 2'b01,2'b00, 2'b01,2'b00);
        add(0,1,2'b11,2'b11, 2'b00,2'b00, 2'b00,2'b00);
        add(0,0,2'b11,2'b11, 2'b10,2'b00, 2'b01,2'b00);
        add(0,0,2'b00,2'b11, 2'b00,2'b00, 2'b00,2'b00);
        add(0,0,2'b00,2'b11, 2'b00,2'b10, 2'b00,2'b01);
        add(0,0,2'b00,2'b11, 2'b00,2'b00, 2'b00,2'b00);
        add(0,0,2'b11,2'b11, 2'b01,2'b00, 2'b01,2'b00);
        add(0,0,2'b11,2'b11, 2'b10,2'b00, 2'b10,2'b00);
        add(0,0,2'b11,2'b11, 2'b00,2'b01, 2'b00,2'b01);
        add(0,0,2'b11,2'b11, 2'b01,2'b10, 2'b01,2'b10);
        add(0,0,2'b11,2'b11, 2'b10,2'b00, 2'b10,2'b00);
        add(0,0,2'b11,2'b11, 2'b00,2'b01, 2'b00,2'b01);
        add(0,0,2'b00,2'b11, 2'b00,2'b10, 2'b00,2'b10);
        add(0,0,2'b00,2'b11, 2'b00,2'b00, 2'b00,2'b00);
        add(0,0,2'b10,2'b00, 2'b10,2'b00, 2'b10,2'b00);
        add(0,0,2'b11,2'b00, 2'b01,2'b00, 2'b01,2'b00);
        add(0,0,2'b11,2'b00, 2'b00,2'b10, 2'b00,2'b10);
        add(0,0,2'b11,2'b00, 2'b00,2'b11, 2'b00,2'b11);
        add(1,0,2'b11,2'b00, 2'b00,2'b11, 2'b00,2'b11);
        add(1,0,2'b11,2'b00, 2'b00,2'b00, 2'b00,2'b00);
        add(0,0,2'b11,2'b11, 2'b01,2'b00, 2'b01,2'b00);
        add(0,0,2'b00,2'b11, 2'b00,2'b00, 2'b00,2'b00);
        add(0,0,2'b00,2'b11, 2'b00,2'b01, 2'b00,2'b01);
        add(0,0,2'b00,2'b11, 2'b00,2'b00, 2'b00,2'b00);

        repeat (2) @(negedge clk);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst = tbl[i].rst; flush = tbl[i].flush;
            req_valid = tbl[i].rv; rsp_ready = tbl[i].rr;
            #1;
            $display("row %0d rst=%b flush=%b req_valid=%b rsp_ready=%b | rr ready=%b rspv=%b | fx ready=%b rspv=%b",
                     i, rst, flush, req_valid, rsp_ready, rr_req_ready, rr_rsp_valid, fx_req_ready, fx_rsp_valid);
            chk($sformatf("row%0d rr req_ready", i), 32'(rr_req_ready), 32'(tbl[i].ready_rr));
            chk($sformatf("row%0d rr rsp_valid", i), 32'(rr_rsp_valid), 32'(tbl[i].rspv_rr));
            chk($sformatf("row%0d fx req_ready", i), 32'(fx_req_ready), 32'(tbl[i].ready_fx));
            chk($sformatf("row%0d fx rsp_valid", i), 32'(fx_rsp_valid), 32'(tbl[i].rspv_fx));
            chk_data($sformatf("row%0d rr", i), tbl[i].rspv_rr, rr_rsp_r0, rr_rsp_flags0, rr_rsp_r1, rr_rsp_flags1);
            chk_data($sformatf("row%0d fx", i), tbl[i].rspv_fx, fx_rsp_r0, fx_rsp_flags0, fx_rsp_r1, fx_rsp_flags1);
        end

        // Operand capture, hold and pass-through of shamt/alufn on port 1.
        @(negedge clk);
        a1 = 32'd3; b1 = 32'h8000_0009; sh1 = 5'd17; fn1 = 4'hA;
        req_valid = 2'b10; rsp_ready = 2'b00;
        #1;
        $display("seq op capture: grant port 1 a=%0h b=%0h", a1, b1);
        chk("seqA rr req_ready", 32'(rr_req_ready), 32'b10);
        chk("seqA fx req_ready", 32'(fx_req_ready), 32'b10);

        @(negedge clk);
        req_valid = 2'b00; a1 = 32'd99;
        #1;
        chk("seqA alu_a", rr_alu_a, 32'd3);
        chk("seqA alu_b", rr_alu_b, 32'h8000_0009);
        chk("seqA alu_shamt", 32'(rr_alu_shamt), 32'd17);
        chk("seqA alu_alufn", 32'(rr_alu_alufn), 32'hA);
        chk("seqA fx alu_alufn", 32'(fx_alu_alufn), 32'hA);
        chk("seqA fx alu_shamt", 32'(fx_alu_shamt), 32'd17);
        chk("seqA rsp_valid early", 32'(rr_rsp_valid), 32'b00);

        @(negedge clk);
        #1;
        $display("seq op capture: response port 1 r=%0h flags=%b", rr_rsp_r1, rr_rsp_flags1);
        chk("seqA alu_a hold", rr_alu_a, 32'd3);
        chk("seqA rsp_valid", 32'(rr_rsp_valid), 32'b10);
        chk("seqA rsp_r1", rr_rsp_r1, 32'h8000_000A);
        chk("seqA rsp_flags1", 32'(rr_rsp_flags1), 32'b0001);

        @(negedge clk);
        req_valid = 2'b10;
        #1;
        chk("seqA busy blocks grant", 32'(rr_req_ready), 32'b00);
        chk("seqA rsp_r1 stable", rr_rsp_r1, 32'h8000_000A);

        @(negedge clk);
        rsp_ready = 2'b10;
        #1;
        chk("seqA handshake cycle ready", 32'(rr_req_ready), 32'b00);
        chk("seqA handshake cycle rspv", 32'(rr_rsp_valid), 32'b10);

        @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        $display("seq op capture: port 1 eligible again ready=%b", rr_req_ready);
        chk("seqA regrant after handshake", 32'(rr_req_ready), 32'b10);
        chk("seqA rsp_valid cleared", 32'(rr_rsp_valid), 32'b00);

        // Reset with work in flight must clear registered outputs and drop the response.
        @(negedge clk);
        rst = 1'b1; req_valid = 2'b00;
        #1;
        chk("seqB ready in reset", 32'(rr_req_ready), 32'b00);

        @(negedge clk);
        rst = 1'b0;
        #1;
        $display("seq reset: alu_a=%0h rsp_r0=%0h rsp_r1=%0h rspv=%b", rr_alu_a, rr_rsp_r0, rr_rsp_r1, rr_rsp_valid);
        chk("seqB alu_a", rr_alu_a, 32'd0);
        chk("seqB alu_b", rr_alu_b, 32'd0);
        chk("seqB alu_shamt", 32'(rr_alu_shamt), 32'd0);
        chk("seqB alu_alufn", 32'(rr_alu_alufn), 32'd0);
        chk("seqB rsp_r0", rr_rsp_r0, 32'd0);
        chk("seqB rsp_r1", rr_rsp_r1, 32'd0);
        chk("seqB rsp_flags1", 32'(rr_rsp_flags1), 32'd0);
        chk("seqB rsp_valid", 32'(rr_rsp_valid), 32'b00);

        @(negedge clk);
        #1;
        chk("seqB no late response", 32'(rr_rsp_valid), 32'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
